// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Purpose:
//   Shares the single register-file write port between NUM_SRC writeback
//   sources (e.g. ALU, muldiv, load) using round-robin arbitration. It also
//   keeps a per-register busy scoreboard for the decode stage. Issuing an
//   instruction sets its destination's busy bit. The write-port cycle for
//   that register clears the bit.
//
// Ports:
//   clock             in   single clock, all state updates on posedge
//   ctrl_reset        in   synchronous, active-high reset
//   wb_valid          in   [NUM_SRC]         per-source writeback request
//   wb_reg            in   [5*NUM_SRC]       per-source destination, src i at [5i+4:5i]
//   wb_data           in   [DATA_W*NUM_SRC]  per-source result, src i at [DATA_W*i +: DATA_W]
//   wb_ready          out  [NUM_SRC]         one-hot grant
//   iss_valid         in   decode issues an instruction writing iss_reg
//   iss_reg           in   [5] destination of the issuing instruction
//   iss_ready         out  issue allowed (target not busy, or target is r0)
//   rd_regA, rd_regB  in   [5] source registers of the instruction in decode
//   stall             out  busy[rd_regA] | busy[rd_regB]
//   ctrl_writeEnable  out  registered regfile write enable
//   ctrl_writeReg     out  [5] registered regfile write address
//   data_writeReg     out  [DATA_W] registered regfile write data
//   busy_vec          out  [32] scoreboard contents, bit 0 always 0
//
// Handshake (valid/ready):
//   A transfer from source i happens in any cycle where wb_valid[i] and
//   wb_ready[i] are both high at the rising clock edge. A source asserting
//   wb_valid must hold wb_valid, wb_reg and wb_data stable until that
//   transfer occurs. wb_ready is computed from wb_valid and internal state
//   only. It never depends on a ready input, so no valid->ready->valid loop
//   can form. At most one wb_ready bit is high per cycle.
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
    parameter int NUM_SRC = 3,   // number of writeback requesters, >= 2
    parameter int DATA_W  = 32   // writeback data width, matches the regfile
) (
    input  logic                      clock,
    input  logic                      ctrl_reset,
    input  logic [NUM_SRC-1:0]        wb_valid,
    input  logic [5*NUM_SRC-1:0]      wb_reg,
    input  logic [DATA_W*NUM_SRC-1:0] wb_data,
    output logic [NUM_SRC-1:0]        wb_ready,
    input  logic                      iss_valid,
    input  logic [4:0]                iss_reg,
    output logic                      iss_ready,
    input  logic [4:0]                rd_regA,
    input  logic [4:0]                rd_regB,
    output logic                      stall,
    output logic                      ctrl_writeEnable,
    output logic [4:0]                ctrl_writeReg,
    output logic [DATA_W-1:0]         data_writeReg,
    output logic [31:0]               busy_vec
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Modular arithmetic runs one bit wider than the pointer. ptr + k is at
    // most 2*NUM_SRC-1, and that value always fits in PTR_W+1 bits.
    localparam logic [PTR_W:0]   SRC_CNT  = (PTR_W + 1)'(NUM_SRC);
    localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SRC - 1);

    // Round-robin pointer. It holds the index of the last granted source.
    logic [PTR_W-1:0] rr_ptr;

    logic             grant_any;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   scan_sum;
    logic [PTR_W-1:0] scan_idx;

    // Per-source fields, unpacked from the flat input buses.
    logic [4:0]        src_reg  [NUM_SRC];
    logic [DATA_W-1:0] src_data [NUM_SRC];

    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic [31:0] busy_q;
    logic [31:0] busy_next;
    logic        iss_fire;

    // ------------------------------------------------------------------
    // Source unpacking
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_reg[i]  = wb_reg[5*i +: 5];
            src_data[i] = wb_data[DATA_W*i +: DATA_W];
        end
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration. The search starts one past the last grant
    // and wraps modulo NUM_SRC. The first valid source found wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        wb_ready  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (scan_sum >= SRC_CNT) begin
                scan_sum = scan_sum - SRC_CNT;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_any && wb_valid[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
        // During reset nothing is granted, so no source believes it was accepted.
        if (ctrl_reset) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            wb_ready[grant_idx] = 1'b1;
        end
    end

    // Fields of the winning source. They are only used when grant_any is high.
    always_comb begin
        sel_reg  = src_reg[grant_idx];
        sel_data = src_data[grant_idx];
    end

    // ------------------------------------------------------------------
    // Issue / stall decisions for the decode stage
    // ------------------------------------------------------------------
    always_comb begin
        iss_ready = 1'b0;
        if (!ctrl_reset) begin
            iss_ready = (iss_reg == 5'd0) || !busy_q[iss_reg];
        end
        iss_fire = iss_valid && iss_ready && (iss_reg != 5'd0);
        stall    = busy_q[rd_regA] | busy_q[rd_regB];
        busy_vec = busy_q;
    end

    // ------------------------------------------------------------------
    // Scoreboard next state
    // ------------------------------------------------------------------
    // The clear happens at the edge that ends the write-port cycle, so
    // decode still sees the register busy while its write is on the port.
    // iss_ready is low for a busy target, so a set and a clear normally
    // hit different bits. Bit 0 is forced low so r0 can never stall.
    always_comb begin
        busy_next = busy_q;
        if (ctrl_writeEnable) begin
            busy_next[ctrl_writeReg] = 1'b0;
        end
        if (iss_fire) begin
            busy_next[iss_reg] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // State registers: pointer, write port, scoreboard
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            rr_ptr           <= LAST_SRC;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= 5'd0;
            data_writeReg    <= '0;
            busy_q           <= 32'd0;
        end else begin
            busy_q <= busy_next;
            if (grant_any) begin
                rr_ptr <= grant_idx;
            end
            // A transfer to r0 completes the handshake but writes nothing.
            // Address and data hold, as they do for an idle cycle.
            if (grant_any && (sel_reg != 5'd0)) begin
                ctrl_writeEnable <= 1'b1;
                ctrl_writeReg    <= sel_reg;
                data_writeReg    <= sel_data;
            end else begin
                ctrl_writeEnable <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//
// Self-checking bench for regfile_wb_scheduler (NUM_SRC=3, DATA_W=32).
// The reference model is transaction level:
//   - a 32-entry busy array
//   - the index of the last granted source
//   - a queue of writes that are expected on the port in the next cycle
// Inputs change just after the falling edge. Outputs are sampled 1 ns later,
// well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

    localparam int NS = 3;
    localparam int DW = 32;

    logic              clock;
    logic              ctrl_reset;
    logic [NS-1:0]     wb_valid;
    logic [5*NS-1:0]   wb_reg;
    logic [DW*NS-1:0]  wb_data;
    logic [NS-1:0]     wb_ready;
    logic              iss_valid;
    logic [4:0]        iss_reg;
    logic              iss_ready;
    logic [4:0]        rd_regA;
    logic [4:0]        rd_regB;
    logic              stall;
    logic              ctrl_writeEnable;
    logic [4:0]        ctrl_writeReg;
    logic [DW-1:0]     data_writeReg;
    logic [31:0]       busy_vec;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit   [31:0] m_busy;
    int          m_last;          // index of the last granted source
    logic [36:0] exp_q[$];        // {reg, data} expected on the write port next cycle

    regfile_wb_scheduler #(.NUM_SRC(NS), .DATA_W(DW)) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .wb_valid         (wb_valid),
        .wb_reg           (wb_reg),
        .wb_data          (wb_data),
        .wb_ready         (wb_ready),
        .iss_valid        (iss_valid),
        .iss_reg          (iss_reg),
        .iss_ready        (iss_ready),
        .rd_regA          (rd_regA),
        .rd_regB          (rd_regB),
        .stall            (stall),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .busy_vec         (busy_vec)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [NS-1:0] model_grant();
        if (ctrl_reset) return '0;
        for (int k = 1; k <= NS; k++) begin
            int idx;
            idx = (m_last + k) % NS;
            if (wb_valid[idx]) return NS'(1) << idx;
        end
        return '0;
    endfunction

    function automatic bit model_iss_ready();
        if (ctrl_reset) return 1'b0;
        return (iss_reg == 5'd0) || !m_busy[iss_reg];
    endfunction

    function automatic bit model_stall();
        return m_busy[rd_regA] | m_busy[rd_regB];
    endfunction

    // One clock cycle. The model is updated from the values seen before the
    // rising edge. Returns the granted source, or -1 if nothing was granted.
    task automatic tick(output int g);
        logic [NS-1:0] gv;
        bit            isr;
        bit            rst;
        bit            ivalid;
        logic [4:0]    ireg;
        logic [4:0]    r;
        logic [31:0]   d;
        gv     = model_grant();
        isr    = model_iss_ready();
        rst    = ctrl_reset;
        ivalid = iss_valid;
        ireg   = iss_reg;
        g      = -1;
        r      = '0;
        d      = '0;
        for (int i = 0; i < NS; i++) if (gv[i]) g = i;
        if (g >= 0) begin
            r = wb_reg[5*g +: 5];
            d = wb_data[32*g +: 32];
        end
        @(posedge clock);
        if (rst) begin
            m_busy = '0;
            m_last = NS - 1;
            exp_q.delete();
            g = -1;
        end else begin
            if (exp_q.size() > 0) begin
                m_busy[exp_q[0][36:32]] = 1'b0;
                void'(exp_q.pop_front());
            end
            if (ivalid && isr && ireg != 5'd0) m_busy[ireg] = 1'b1;
            if (g >= 0) begin
                m_last = g;
                if (r != 5'd0) exp_q.push_back({r, d});
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        int g;
        ctrl_reset = 1'b1;
        tick(g);
        ctrl_reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        int g;
        ctrl_reset = 1'b1;
        wb_valid   = 3'b111;
        wb_reg     = {5'd3, 5'd2, 5'd1};
        wb_data    = {$urandom, $urandom, $urandom};
        iss_valid  = 1'b1;
        iss_reg    = 5'd5;
        rd_regA    = 5'd5;
        rd_regB    = 5'd6;
        tick(g);
        tick(g);
        #1;
        checks++; if (wb_ready !== 3'b000) begin errors++; $display("FAIL reset_wb_ready: got %b expected 000", wb_ready); end
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL reset_iss_ready: got %b expected 0", iss_ready); end
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", ctrl_writeEnable); end
        checks++; if (ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d expected 0", ctrl_writeReg); end
        checks++; if (data_writeReg !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", data_writeReg); end
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        ctrl_reset = 1'b0;
        wb_valid   = '0;
        iss_valid  = 1'b0;
        #1;
        checks++; if (wb_ready !== 3'b000) begin errors++; $display("FAIL idle_wb_ready: got %b expected 000", wb_ready); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL idle_iss_ready: got %b expected 1", iss_ready); end
        tick(g);
        rd_regA = 5'd0;
        rd_regB = 5'd0;
    endtask

    task automatic test_single_wb();
        int g;
        iss_valid = 1'b1;
        iss_reg   = 5'd5;
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL single_iss_ready: got %b expected 1", iss_ready); end
        tick(g);
        iss_valid = 1'b0;
        #1;
        checks++; if (busy_vec !== 32'h0000_0020) begin errors++; $display("FAIL single_busy_set: got %h expected 00000020", busy_vec); end
        wb_valid        = 3'b010;
        wb_reg[9:5]     = 5'd5;
        wb_data[63:32]  = 32'hDEAD_BEEF;
        #1;
        checks++; if (wb_ready !== 3'b010) begin errors++; $display("FAIL single_grant: got %b expected 010", wb_ready); end
        tick(g);
        wb_valid = '0;
        rd_regA  = 5'd5;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", ctrl_writeEnable); end
        checks++; if (ctrl_writeReg !== 5'd5) begin errors++; $display("FAIL single_wreg: got %0d expected 5", ctrl_writeReg); end
        checks++; if (data_writeReg !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_wdata: got %h expected deadbeef", data_writeReg); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL single_stall_during_write: got %b expected 1", stall); end
        tick(g);
        #1;
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL single_busy_clear: got %h expected 0", busy_vec); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL single_stall_after: got %b expected 0", stall); end
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b expected 0", ctrl_writeEnable); end
        rd_regA = 5'd0;
    endtask

    task automatic test_round_robin();
        int          g;
        logic [4:0]  prev_r;
        logic [31:0] prev_d;
        do_reset();
        for (int i = 0; i < NS; i++) begin
            wb_reg[5*i +: 5]   = 5'(10 + i);
            wb_data[32*i +: 32] = $urandom;
        end
        wb_valid = 3'b111;
        prev_r   = '0;
        prev_d   = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++; if (wb_ready !== (3'b001 << (c % 3))) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, wb_ready, 3'b001 << (c % 3)); end
            if (c > 0) begin
                checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== prev_r || data_writeReg !== prev_d) begin
                    errors++; $display("FAIL rr_write c=%0d: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%h", c, ctrl_writeEnable, ctrl_writeReg, data_writeReg, prev_r, prev_d);
                end
            end
            prev_r = wb_reg[5*(c % 3) +: 5];
            prev_d = wb_data[32*(c % 3) +: 32];
            tick(g);
            if (g >= 0) wb_data[32*g +: 32] = $urandom;
        end
        wb_valid = '0;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== prev_r || data_writeReg !== prev_d) begin
            errors++; $display("FAIL rr_last_write: got we=%b reg=%0d data=%h expected we=1 reg=%0d data=%h", ctrl_writeEnable, ctrl_writeReg, data_writeReg, prev_r, prev_d);
        end
        tick(g);
    endtask

    task automatic test_issue_block();
        int g;
        iss_valid = 1'b1;
        iss_reg   = 5'd7;
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL blk_first_issue: got %b expected 1", iss_ready); end
        tick(g);
        #1;
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL blk_busy_ready: got %b expected 0", iss_ready); end
        tick(g);
        #1;
        checks++; if (busy_vec !== 32'h0000_0080) begin errors++; $display("FAIL blk_busy_hold: got %h expected 00000080", busy_vec); end
        wb_valid            = 3'b100;
        wb_reg[14:10]       = 5'd7;
        wb_data[95:64]      = $urandom;
        #1;
        checks++; if (wb_ready !== 3'b100) begin errors++; $display("FAIL blk_grant: got %b expected 100", wb_ready); end
        tick(g);
        wb_valid = '0;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7) begin errors++; $display("FAIL blk_write: got we=%b reg=%0d expected we=1 reg=7", ctrl_writeEnable, ctrl_writeReg); end
        checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL blk_ready_write_cycle: got %b expected 0", iss_ready); end
        tick(g);
        #1;
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL blk_ready_after: got %b expected 1", iss_ready); end
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL blk_busy_after: got %h expected 0", busy_vec); end
        iss_valid = 1'b0;
    endtask

    task automatic test_reg0();
        int g;
        iss_valid = 1'b1;
        iss_reg   = 5'd12;
        tick(g);
        iss_reg       = 5'd0;
        wb_valid      = 3'b001;
        wb_reg[4:0]   = 5'd0;
        wb_data[31:0] = 32'h0000_1234;
        #1;
        checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL r0_grant: got %b expected 001", wb_ready); end
        checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL r0_iss_ready: got %b expected 1", iss_ready); end
        tick(g);
        wb_valid  = '0;
        iss_valid = 1'b0;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL r0_we: got %b expected 0", ctrl_writeEnable); end
        checks++; if (busy_vec !== 32'h0000_1000) begin errors++; $display("FAIL r0_busy: got %h expected 00001000", busy_vec); end
        tick(g);
    endtask

    task automatic test_reset_midflight();
        int g;
        wb_valid      = 3'b001;
        wb_reg[4:0]   = 5'd3;
        wb_data[31:0] = $urandom;
        #1;
        checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL mid_first_grant: got %b expected 001", wb_ready); end
        tick(g);
        wb_valid       = 3'b010;
        wb_reg[9:5]    = 5'd4;
        wb_data[63:32] = $urandom;
        #1;
        checks++; if (wb_ready !== 3'b010) begin errors++; $display("FAIL mid_second_grant: got %b expected 010", wb_ready); end
        ctrl_reset = 1'b1;
        #1;
        checks++; if (wb_ready !== 3'b000) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 000", wb_ready); end
        tick(g);
        ctrl_reset = 1'b0;
        wb_valid   = 3'b111;
        #1;
        checks++; if (ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL mid_we: got %b expected 0", ctrl_writeEnable); end
        checks++; if (busy_vec !== 32'd0) begin errors++; $display("FAIL mid_busy: got %h expected 0", busy_vec); end
        checks++; if (wb_ready !== 3'b001) begin errors++; $display("FAIL mid_priority: got %b expected 001", wb_ready); end
        tick(g);
        wb_valid = '0;
        tick(g);
    endtask

    task automatic test_random();
        int          g;
        logic [NS-1:0] eg;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (!wb_valid[i] && $urandom_range(0, 2) == 0) begin
                    wb_valid[i]         = 1'b1;
                    wb_reg[5*i +: 5]    = 5'($urandom_range(0, 31));
                    wb_data[32*i +: 32] = $urandom;
                end
            end
            iss_reg   = 5'($urandom_range(0, 31));
            iss_valid = 1'($urandom_range(0, 1));
            // Keep issue away from the register whose write is on the port this cycle.
            if (exp_q.size() > 0 && exp_q[0][36:32] == iss_reg) iss_valid = 1'b0;
            rd_regA = 5'($urandom_range(0, 31));
            rd_regB = 5'($urandom_range(0, 31));
            #1;
            eg = model_grant();
            checks++; if (wb_ready !== eg) begin errors++; $display("FAIL rnd_grant c=%0d: got %b expected %b", c, wb_ready, eg); end
            checks++; if (iss_ready !== model_iss_ready()) begin errors++; $display("FAIL rnd_iss_ready c=%0d: got %b expected %b", c, iss_ready, model_iss_ready()); end
            checks++; if (stall !== model_stall()) begin errors++; $display("FAIL rnd_stall c=%0d: got %b expected %b", c, stall, model_stall()); end
            checks++; if (busy_vec !== m_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %h expected %h", c, busy_vec, m_busy); end
            checks++; if (ctrl_writeEnable !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_we c=%0d: got %b expected %b", c, ctrl_writeEnable, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                checks++; if ({ctrl_writeReg, data_writeReg} !== exp_q[0]) begin
                    errors++; $display("FAIL rnd_write c=%0d: got reg=%0d data=%h expected reg=%0d data=%h", c, ctrl_writeReg, data_writeReg, exp_q[0][36:32], exp_q[0][31:0]);
                end
            end
            tick(g);
            if (g >= 0) wb_valid[g] = 1'b0;
        end
        wb_valid  = '0;
        iss_valid = 1'b0;
        tick(g);
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        ctrl_reset = 1'b1;
        wb_valid   = '0;
        wb_reg     = '0;
        wb_data    = '0;
        iss_valid  = 1'b0;
        iss_reg    = '0;
        rd_regA    = '0;
        rd_regB    = '0;
        m_busy     = '0;
        m_last     = NS - 1;
        @(negedge clock);
        test_reset();
        test_single_wb();
        test_round_robin();
        test_issue_block();
        test_reg0();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
